// File: rtl/mem_port_arbiter.sv
// Shared single-port memory sequencer for the IF and MEM pipeline stages.
// Grants one requester at a time from IDLE, holds the memory for WAIT_CYCLES
// cycles in ACCESS, then pulses the granted port's ack in RESP.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // Counter preload so that ACCESS spans exactly WAIT_CYCLES cycles.
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t     state;
  logic       last_grant;  // 1 = data side was granted last
  logic       port_q;      // 1 = access in flight belongs to the data side
  logic [3:0] cnt;
  logic       data_req;
  logic       grant_data;

  assign data_req = mem_read | mem_write;
  // Data wins when IF is idle, or on a tie when IF had the previous grant.
  assign grant_data = data_req & (~if_req | ~last_grant);

  // Stall holds the pipeline until each outstanding request sees its ack.
  assign stall = (data_req & ~mem_ack) | (if_req & ~if_ack);

  // Single FSM with all outputs registered; ram_we doubles as the write latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      port_q     <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      if_ack     <= 1'b0;
      mem_ack    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req | data_req) begin
            state      <= ACCESS;
            busy       <= 1'b1;
            ram_en     <= 1'b1;
            cnt        <= CNT_INIT;
            port_q     <= grant_data;
            last_grant <= grant_data;
            if (grant_data) begin
              ram_addr  <= mem_addr;
              ram_we    <= mem_write;  // read+write together is a write
              ram_wdata <= mem_wdata;
            end else begin
              ram_addr <= if_addr;
              ram_we   <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state  <= RESP;
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            if (!ram_we) begin
              if (port_q) mem_rdata <= ram_rdata;
              else        if_rdata  <= ram_rdata;
            end
            if (port_q) mem_ack <= 1'b1;
            else        if_ack  <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state   <= IDLE;
          busy    <= 1'b0;
          if_ack  <= 1'b0;
          mem_ack <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with WAIT_CYCLES=2.
// Inputs change 1ns after a rising edge; outputs are checked at that point.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        stall;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int acks_seen;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .stall(stall), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; if_req = 0; if_addr = 0; mem_read = 0; mem_write = 0;
    mem_addr = 0; mem_wdata = 0; ram_rdata = 0;
    tick(); tick();
    // Reset state
    chk("rst_ram_en", 32'(ram_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_acks", {30'd0, if_ack, mem_ack}, 0);
    chk("rst_rdata", if_rdata | mem_rdata, 0);
    rst = 1'b0;
    tick();

    // 1: instruction fetch
    if_req = 1; if_addr = 32'h40; ram_rdata = 32'h8C010004;
    #1 chk("t1_stall_pre", 32'(stall), 1);
    tick();
    chk("t1_en0", 32'(ram_en), 1);
    chk("t1_addr0", ram_addr, 32'h40);
    chk("t1_we0", 32'(ram_we), 0);
    chk("t1_busy0", 32'(busy), 1);
    chk("t1_ack0", 32'(if_ack), 0);
    tick();
    chk("t1_en1", 32'(ram_en), 1);
    chk("t1_ack1", 32'(if_ack), 0);
    chk("t1_stall1", 32'(stall), 1);
    tick();
    chk("t1_en2", 32'(ram_en), 0);
    chk("t1_ack2", 32'(if_ack), 1);
    chk("t1_mack2", 32'(mem_ack), 0);
    chk("t1_rdata", if_rdata, 32'h8C010004);
    chk("t1_stall2", 32'(stall), 0);
    if_req = 0;
    tick();
    chk("t1_ack3", 32'(if_ack), 0);
    chk("t1_busy3", 32'(busy), 0);
    chk("t1_rdata_hold", if_rdata, 32'h8C010004);

    // 2: store; operand changes mid-access must not leak through
    mem_write = 1; mem_addr = 32'h100; mem_wdata = 32'hDEADBEEF; ram_rdata = 32'h12345678;
    tick();
    chk("t2_we0", 32'(ram_we), 1);
    chk("t2_addr0", ram_addr, 32'h100);
    chk("t2_wdata0", ram_wdata, 32'hDEADBEEF);
    mem_addr = 32'h777; mem_wdata = 32'h0;
    tick();
    chk("t2_we1", 32'(ram_we), 1);
    chk("t2_addr1", ram_addr, 32'h100);
    chk("t2_wdata1", ram_wdata, 32'hDEADBEEF);
    chk("t2_mack1", 32'(mem_ack), 0);
    tick();
    chk("t2_mack2", 32'(mem_ack), 1);
    chk("t2_we2", 32'(ram_we), 0);
    chk("t2_iack2", 32'(if_ack), 0);
    chk("t2_mrdata", mem_rdata, 0);
    chk("t2_stall2", 32'(stall), 0);
    mem_write = 0;
    tick();
    chk("t2_mack3", 32'(mem_ack), 0);

    // 3/4: tie from reset goes to data, then alternates; IF not starved
    do_reset();
    if_req = 1; if_addr = 32'h80; mem_read = 1; mem_addr = 32'h200; ram_rdata = 32'hAAAA0001;
    tick();
    chk("t3_addr_d", ram_addr, 32'h200);
    tick(); tick();
    chk("t3_mack", 32'(mem_ack), 1);
    chk("t3_iack0", 32'(if_ack), 0);
    chk("t3_mrdata", mem_rdata, 32'hAAAA0001);
    chk("t3_stall", 32'(stall), 1);
    ram_rdata = 32'hBBBB0002;
    tick();
    chk("t3_idle", 32'(busy), 0);
    tick();
    chk("t3_addr_i", ram_addr, 32'h80);
    tick(); tick();
    chk("t3_iack", 32'(if_ack), 1);
    chk("t3_mack_n", 32'(mem_ack), 0);
    chk("t3_irdata", if_rdata, 32'hBBBB0002);
    chk("t3_mrdata_hold", mem_rdata, 32'hAAAA0001);
    tick(); tick();
    chk("t3_addr_d2", ram_addr, 32'h200);
    tick(); tick();
    chk("t3_mack2", 32'(mem_ack), 1);
    if_req = 0; mem_read = 0;
    tick();

    // 5: reset during second ACCESS cycle abandons the access
    mem_read = 1; mem_addr = 32'h300; ram_rdata = 32'h55555555;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("t5_en_rst", 32'(ram_en), 0);
    chk("t5_busy_rst", 32'(busy), 0);
    mem_read = 0;
    tick();
    rst = 1'b0;
    acks_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      acks_seen += int'(mem_ack) + int'(if_ack) + int'(ram_en);
    end
    chk("t5_no_ack", 32'(acks_seen), 0);
    mem_read = 1; mem_addr = 32'h44; ram_rdata = 32'hCAFE0005;
    tick();
    chk("t5_addr", ram_addr, 32'h44);
    tick(); tick();
    chk("t5_mack", 32'(mem_ack), 1);
    chk("t5_mrdata", mem_rdata, 32'hCAFE0005);
    mem_read = 0;
    tick();

    // 6: read+write together is a write
    mem_read = 1; mem_write = 1; mem_addr = 32'h50; mem_wdata = 32'h11112222;
    ram_rdata = 32'h99999999;
    tick();
    chk("t6_we", 32'(ram_we), 1);
    chk("t6_wdata", ram_wdata, 32'h11112222);
    tick(); tick();
    chk("t6_mack", 32'(mem_ack), 1);
    chk("t6_mrdata", mem_rdata, 32'hCAFE0005);
    mem_read = 0; mem_write = 0;
    tick();
    chk("t6_mack_off", 32'(mem_ack), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
